// File: rtl/mem_ctrl_pkg.sv
// Shared types for the multi-port memory controller: FSM states and arbitration modes.
package mem_ctrl_pkg;

    typedef enum logic {
        IDLE,
        ACCESS
    } mc_state_t;

    typedef enum logic {
        ARB_RR,
        ARB_FIXED
    } arb_mode_t;

endpackage

// File: rtl/multi_port_mem_controller_if.sv
// Requester-side and downstream generic-bus signals of the multi-port memory controller.
interface multi_port_mem_controller_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    localparam int ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BE_W = DATA_W / 8;

    logic [NUM_PORTS-1:0]        req_ren;
    logic [NUM_PORTS-1:0]        req_wen;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS*BE_W-1:0]   req_byte_en;
    logic [DATA_W-1:0]           req_rdata;
    logic [NUM_PORTS-1:0]        req_busy;

    logic                        out_ren;
    logic                        out_wen;
    logic [ADDR_W-1:0]           out_addr;
    logic [DATA_W-1:0]           out_wdata;
    logic [BE_W-1:0]             out_byte_en;
    logic [DATA_W-1:0]           out_rdata;
    logic                        out_busy;

    logic [ID_W-1:0]             grant_id;

    // Controller side: consumes requests and downstream responses.
    modport slave (
        input  req_ren, req_wen, req_addr, req_wdata, req_byte_en, out_rdata, out_busy,
        output req_rdata, req_busy, out_ren, out_wen, out_addr, out_wdata, out_byte_en,
               grant_id
    );

    // Environment side: requesters plus the downstream bus.
    modport master (
        output req_ren, req_wen, req_addr, req_wdata, req_byte_en, out_rdata, out_busy,
        input  req_rdata, req_busy, out_ren, out_wen, out_addr, out_wdata, out_byte_en,
               grant_id
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational request picker: cyclic search from ptr (round-robin) or lowest index (fixed).
module rr_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int N = 2,
    localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  arb_mode_t       mode,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            any_req
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            if (mode == ARB_RR) idx = ID_W'((int'(ptr) + k) % N);
            else                idx = ID_W'(k);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/multi_port_mem_controller.sv
// N-port arbiter latching one granted request at a time onto a single downstream generic bus.
//   state  | meaning
//   IDLE   | bus quiet, all ports busy; a winner is latched on the edge if anyone requests
//   ACCESS | latched transfer driven downstream; owner's busy follows out_busy
module multi_port_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ARB_MODE  = 0
) (
    input  logic CLK,
    input  logic nRST,
    multi_port_mem_controller_if.slave bus
);

    localparam int        ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int        BE_W = DATA_W / 8;
    localparam arb_mode_t MODE = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

    mc_state_t         state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, gid_q, arb_idx;
    logic [NUM_PORTS-1:0] arb_grant, busy_c;
    logic              any_req, load, done, ren_c, wen_c;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              wr_q, rd_q;

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .req       (bus.req_ren | bus.req_wen),
        .ptr       (rr_ptr),
        .mode      (MODE),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (any_req)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_c    = '1;
        ren_c     = 1'b0;
        wen_c     = 1'b0;
        load      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    load      = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                ren_c         = rd_q;
                wen_c         = wr_q;
                busy_c[gid_q] = bus.out_busy;
                if (!bus.out_busy) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A port raising both ren and wen is latched as a write only.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            gid_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else if (load) begin
            gid_q   <= arb_idx;
            addr_q  <= bus.req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
            wdata_q <= bus.req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
            be_q    <= bus.req_byte_en[int'(arb_idx)*BE_W +: BE_W];
            wr_q    <= |(arb_grant & bus.req_wen);
            rd_q    <= |(arb_grant & bus.req_ren & ~bus.req_wen);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr <= '0;
        end else if (done && MODE == ARB_RR) begin
            rr_ptr <= (gid_q == ID_W'(NUM_PORTS - 1)) ? '0 : gid_q + 1'b1;
        end
    end

    assign bus.out_ren     = ren_c;
    assign bus.out_wen     = wen_c;
    assign bus.out_addr    = addr_q;
    assign bus.out_wdata   = wdata_q;
    assign bus.out_byte_en = be_q;
    assign bus.req_busy    = busy_c;
    assign bus.req_rdata   = bus.out_rdata;
    assign bus.grant_id    = gid_q;

endmodule
